add_sub_seq: RTL



---
 rtl/add_sub_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/add_sub_seq.sv
// add_sub_seq: multi-cycle adder/subtractor.
//
// Adds or subtracts a WIDTH-bit operand pair SLICE bits per clock. The carry
// between slices is held in a register, so one SLICE-bit ripple chain is
// reused N = WIDTH/SLICE times. Valid/ready handshakes are used on both sides.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of SLICE
//   SLICE  bits per clock (1..WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand set present
//   in_ready   block can accept an operand set (IDLE and not in reset)
//   sub        0: in_1 + in_2 + c_in, 1: in_1 + ~in_2 + c_in
//   c_in       carry-in (set to 1 with sub=1 for two's-complement subtract)
//   in_1/in_2  operands
//   out_valid  result held and valid (DONE)
//   out_ready  consumer accepts the result
//   out        result (modulo 2^WIDTH)
//   c_out      carry out of bit WIDTH-1 (0 = borrow when subtracting)
//   ovf        signed overflow
//   zero       out == 0
//
// Optional feature macro: ADD_SUB_SEQ_FLAGS_EN
//   When defined, ovf and zero are computed and registered.
//   When undefined, ovf and zero are tied to 0.

module add_sub_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             c_in,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [KW-1:0]    k;        // slice index being computed
    logic [WIDTH-1:0] op_a;     // latched in_1
    logic [WIDTH-1:0] op_b;     // latched in_2, already inverted for sub
    logic [WIDTH-1:0] acc;      // partial result, filled slice by slice
    logic             carry;    // carry into the current slice

    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] sum_s;
    logic [SLICE:0]   cy;       // cy[i] = carry into bit i of the slice
    logic [WIDTH-1:0] res_full; // acc with the current slice merged in
    logic             last;

    // Handshake outputs depend on state (and reset) only, never on
    // in_valid or out_ready.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = rst_n && (state == DONE);

    assign a_s  = op_a[k*SLICE +: SLICE];
    assign b_s  = op_b[k*SLICE +: SLICE];
    assign last = (k == K_LAST);

    // SLICE-bit ripple-carry chain fed from the carry register.
    assign cy[0] = carry;
    for (genvar i = 0; i < SLICE; i++) begin : g_rca
        assign sum_s[i]  = a_s[i] ^ b_s[i] ^ cy[i];
        assign cy[i + 1] = (a_s[i] & b_s[i]) | (cy[i] & (a_s[i] ^ b_s[i]));
    end

    // On the last slice this is the complete result, so out and zero can be
    // taken on the same edge as the final slice without an extra cycle.
    always_comb begin
        res_full = acc;
        res_full[k*SLICE +: SLICE] = sum_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            out   <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= in_1;
                        op_b  <= sub ? ~in_2 : in_2;
                        carry <= c_in;
                        k     <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= res_full;
                    carry <= cy[SLICE];
                    if (last) begin
                        // out/c_out only change here, so they hold the last
                        // result through DONE and the following IDLE.
                        out   <= res_full;
                        c_out <= cy[SLICE];
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADD_SUB_SEQ_FLAGS_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    // The MSB is always the top bit of the final slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (state == CALC && last) begin
            ovf  <= cy[SLICE] ^ cy[SLICE-1];
            zero <= (res_full == '0);
        end
    end
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule
